// File: rtl/ibex_branch_predict_bht.sv
// Branch history table predictor.
// Decodes the fetched instruction, forms the branch/jump target and predicts
// its direction. Each entry holds a valid bit and a saturating counter. The
// table is indexed by PC[IdxW:1] and has no tag. Lookup is purely
// combinational and reads the table as it stands before any update or flush
// in the same cycle.
module ibex_branch_predict_bht #(
    parameter int unsigned BhtEntries = 64,
    parameter int unsigned CtrWidth   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] fetch_rdata_i,
    input  logic [31:0] fetch_pc_i,
    input  logic        fetch_valid_i,
    input  logic        update_valid_i,
    input  logic [31:0] update_pc_i,
    input  logic        update_taken_i,
    input  logic        flush_i,
    output logic        predict_branch_taken_o,
    output logic [31:0] predict_branch_pc_o,
    output logic        predict_bht_hit_o
);

    localparam int unsigned IdxW = (BhtEntries > 1) ? $clog2(BhtEntries) : 1;
    localparam logic [CtrWidth-1:0] CtrMax   = '1;
    localparam logic [CtrWidth-1:0] CtrWeakT = CtrWidth'(2 ** (CtrWidth - 1));
    localparam logic [CtrWidth-1:0] CtrWeakN = CtrWidth'(2 ** (CtrWidth - 1) - 1);
    localparam bit ParamsOk = (BhtEntries >= 2) && (BhtEntries <= 1024) &&
                              ((BhtEntries & (BhtEntries - 1)) == 0) &&
                              (CtrWidth >= 1) && (CtrWidth <= 4);

    // Table state
    logic                r_valid [BhtEntries];
    logic [CtrWidth-1:0] r_ctr   [BhtEntries];

    // Decode
    logic [31:0]         w_instr;
    logic                w_is_jal;
    logic                w_is_branch;
    logic                w_is_cj;
    logic                w_is_cb;
    logic [31:0]         w_imm_j;
    logic [31:0]         w_imm_b;
    logic [31:0]         w_imm_cj;
    logic [31:0]         w_imm_cb;
    logic [31:0]         w_imm;
    logic                w_is_jump;
    logic                w_is_cond;

    // Table access
    logic [IdxW-1:0]     w_lookup_idx;
    logic [IdxW-1:0]     w_upd_idx;
    logic                w_lookup_valid;
    logic [CtrWidth-1:0] w_lookup_ctr;
    logic                w_upd_entry_valid;
    logic [CtrWidth-1:0] w_upd_entry_ctr;
    logic [CtrWidth-1:0] w_upd_ctr_next;
    logic                w_unused;

    assign w_instr = fetch_rdata_i;

    assign w_is_jal    = (w_instr[6:0] == 7'b1101111);
    assign w_is_branch = (w_instr[6:0] == 7'b1100011);
    assign w_is_cj     = (w_instr[1:0] == 2'b01) &&
                         ((w_instr[15:13] == 3'b101) || (w_instr[15:13] == 3'b001));
    assign w_is_cb     = (w_instr[1:0] == 2'b01) && (w_instr[15:14] == 2'b11);

    assign w_imm_j  = {{12{w_instr[31]}}, w_instr[19:12], w_instr[20],
                       w_instr[30:21], 1'b0};
    assign w_imm_b  = {{20{w_instr[31]}}, w_instr[7], w_instr[30:25],
                       w_instr[11:8], 1'b0};
    assign w_imm_cj = {{21{w_instr[12]}}, w_instr[8], w_instr[10:9], w_instr[6],
                       w_instr[7], w_instr[2], w_instr[11], w_instr[5:3], 1'b0};
    assign w_imm_cb = {{24{w_instr[12]}}, w_instr[6:5], w_instr[2],
                       w_instr[11:10], w_instr[4:3], 1'b0};

    assign w_is_jump = w_is_jal || w_is_cj;
    assign w_is_cond = w_is_branch || w_is_cb;

    assign w_lookup_idx      = fetch_pc_i[IdxW:1];
    assign w_upd_idx         = update_pc_i[IdxW:1];
    assign w_lookup_valid    = r_valid[w_lookup_idx];
    assign w_lookup_ctr      = r_ctr[w_lookup_idx];
    assign w_upd_entry_valid = r_valid[w_upd_idx];
    assign w_upd_entry_ctr   = r_ctr[w_upd_idx];

    // Upper update PC bits are not part of the index
    assign w_unused = ^{update_pc_i[31:IdxW+1], update_pc_i[0]};

    // Immediate select; B-type is the fallback when nothing decodes
    always_comb begin
        w_imm = w_imm_b;
        if (w_is_jal) begin
            w_imm = w_imm_j;
        end else if (w_is_cj) begin
            w_imm = w_imm_cj;
        end else if (w_is_cb) begin
            w_imm = w_imm_cb;
        end
    end

    // Prediction outputs, gated by fetch valid
    always_comb begin
        predict_branch_taken_o = 1'b0;
        predict_bht_hit_o      = 1'b0;
        predict_branch_pc_o    = fetch_pc_i + w_imm;
        if (fetch_valid_i) begin
            if (w_is_jump) begin
                predict_branch_taken_o = 1'b1;
            end else if (w_is_cond) begin
                if (w_lookup_valid) begin
                    predict_branch_taken_o = w_lookup_ctr[CtrWidth-1];
                    predict_bht_hit_o      = 1'b1;
                end else begin
                    predict_branch_taken_o = w_imm[31];
                end
            end
        end
    end

    // Next counter value for an update: saturating step or fresh weak state
    always_comb begin
        w_upd_ctr_next = w_upd_entry_ctr;
        if (!w_upd_entry_valid) begin
            w_upd_ctr_next = update_taken_i ? CtrWeakT : CtrWeakN;
        end else if (update_taken_i) begin
            if (w_upd_entry_ctr != CtrMax) begin
                w_upd_ctr_next = w_upd_entry_ctr + 1'b1;
            end
        end else begin
            if (w_upd_entry_ctr != '0) begin
                w_upd_ctr_next = w_upd_entry_ctr - 1'b1;
            end
        end
    end

    // Table update: reset clears everything, flush clears valids and wins over update
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < BhtEntries; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= '0;
            end
        end else if (flush_i) begin
            for (int unsigned i = 0; i < BhtEntries; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (update_valid_i) begin
            r_valid[w_upd_idx] <= 1'b1;
            r_ctr[w_upd_idx]   <= w_upd_ctr_next;
        end
    end

    // Parameter legality and mutually exclusive instruction decodes
    assert property (@(posedge clk_i) ParamsOk);
    assert property (@(posedge clk_i) disable iff (rst_i)
        fetch_valid_i |-> $onehot0({w_is_jal, w_is_branch, w_is_cj, w_is_cb}));

endmodule

// File: tb/tb_ibex_branch_predict_bht.sv
// Directed bench for ibex_branch_predict_bht with hand-computed expectations.
module tb_ibex_branch_predict_bht;

    localparam logic [31:0] BEQ_NEG8  = 32'hFE000CE3; // beq x0,x0,-8
    localparam logic [31:0] BEQ_POS8  = 32'h00000463; // beq x0,x0,+8
    localparam logic [31:0] CJ_POS4   = 32'h0000A011; // c.j +4
    localparam logic [31:0] JAL_POS16 = 32'h0100006F; // jal x0,+16
    localparam logic [31:0] ADDI_NOP  = 32'h00000013; // addi x0,x0,0
    localparam logic [31:0] CBEQZ_M2  = 32'h0000DC7D; // c.beqz x8,-2

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_rdata;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic        flush;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        pred_hit;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    ibex_branch_predict_bht #(
        .BhtEntries(64),
        .CtrWidth  (2)
    ) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .fetch_rdata_i         (fetch_rdata),
        .fetch_pc_i            (fetch_pc),
        .fetch_valid_i         (fetch_valid),
        .update_valid_i        (update_valid),
        .update_pc_i           (update_pc),
        .update_taken_i        (update_taken),
        .flush_i               (flush),
        .predict_branch_taken_o(pred_taken),
        .predict_branch_pc_o   (pred_pc),
        .predict_bht_hit_o     (pred_hit)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
        fetch_pc    = pc;
        fetch_rdata = instr;
        fetch_valid = 1'b1;
        #1;
    endtask

    task automatic upd(input logic v, input logic [31:0] pc, input logic t);
        update_valid = v;
        update_pc    = pc;
        update_taken = t;
    endtask

    task automatic expect_pred(input string tag, input logic t, input logic [31:0] pc,
                               input logic h);
        check({tag, ".taken"}, {31'b0, pred_taken}, {31'b0, t});
        check({tag, ".pc"}, pred_pc, pc);
        check({tag, ".hit"}, {31'b0, pred_hit}, {31'b0, h});
    endtask

    // Taken inputs and expected predicted direction; counter walks
    // 1 -> 2,3,3 (sat) -> 2,1,0,0 (sat) -> 1,2
    logic [8:0] seq_t   = 9'b110000111; // bit i = update i
    logic [8:0] seq_exp = 9'b100001111;

    initial begin
        rst          = 1'b1;
        fetch_rdata  = BEQ_NEG8;
        fetch_pc     = 32'h100;
        fetch_valid  = 1'b0;
        flush        = 1'b0;
        upd(1'b0, 32'h0, 1'b0);
        #3;
        check("reset.taken", {31'b0, pred_taken}, 32'd0);
        check("reset.hit", {31'b0, pred_hit}, 32'd0);
        step();
        step();
        rst = 1'b0;

        // Static prediction on an empty table
        fetch(32'h100, BEQ_NEG8);
        expect_pred("static_back", 1'b1, 32'h0F8, 1'b0);
        fetch(32'h100, BEQ_POS8);
        expect_pred("static_fwd", 1'b0, 32'h108, 1'b0);

        // First update allocates weak not-taken; same-cycle lookup sees old table
        step();
        upd(1'b1, 32'h100, 1'b0);
        fetch(32'h100, BEQ_NEG8);
        expect_pred("rbw", 1'b1, 32'h0F8, 1'b0);
        step();
        upd(1'b0, 32'h0, 1'b0);
        fetch(32'h100, BEQ_NEG8);
        expect_pred("alloc_nt", 1'b0, 32'h0F8, 1'b1);

        // Saturating counter walk
        for (int i = 0; i < 9; i++) begin
            step();
            upd(1'b1, 32'h100, seq_t[i]);
            step();
            upd(1'b0, 32'h0, 1'b0);
            fetch(32'h100, BEQ_POS8);
            expect_pred($sformatf("walk%0d", i), seq_exp[i], 32'h108, 1'b1);
        end

        // 0x180 aliases index 0 (ctr 2 -> 1)
        step();
        upd(1'b1, 32'h180, 1'b0);
        step();
        upd(1'b0, 32'h0, 1'b0);
        fetch(32'h100, BEQ_POS8);
        expect_pred("alias_100", 1'b0, 32'h108, 1'b1);
        fetch(32'h180, BEQ_POS8);
        expect_pred("alias_180", 1'b0, 32'h188, 1'b1);

        // update_taken/pc ignored without update_valid
        step();
        upd(1'b0, 32'h100, 1'b1);
        step();
        fetch(32'h100, BEQ_POS8);
        expect_pred("upd_idle", 1'b0, 32'h108, 1'b1);

        step();
        upd(1'b1, 32'h180, 1'b1);
        step();
        upd(1'b0, 32'h0, 1'b0);
        fetch(32'h100, BEQ_POS8);
        expect_pred("alias_t", 1'b1, 32'h108, 1'b1);

        // Jumps and other instruction types
        fetch(32'h200, CJ_POS4);
        expect_pred("cj", 1'b1, 32'h204, 1'b0);
        fetch(32'h400, JAL_POS16);
        expect_pred("jal", 1'b1, 32'h410, 1'b0);
        step();
        fetch(32'h500, ADDI_NOP);
        expect_pred("addi", 1'b0, 32'h500, 1'b0);
        fetch(32'h302, CBEQZ_M2);
        expect_pred("cbeqz", 1'b1, 32'h300, 1'b0);

        // Flush with coincident update: update dropped, lookup sees pre-flush
        step();
        flush = 1'b1;
        upd(1'b1, 32'h302, 1'b0);
        fetch(32'h100, BEQ_POS8);
        expect_pred("preflush", 1'b1, 32'h108, 1'b1);
        step();
        flush = 1'b0;
        upd(1'b0, 32'h0, 1'b0);
        fetch(32'h100, BEQ_POS8);
        expect_pred("postflush", 1'b0, 32'h108, 1'b0);
        fetch(32'h302, CBEQZ_M2);
        expect_pred("flush_drop", 1'b1, 32'h300, 1'b0);

        // Re-arm index 0, then reset mid-cycle with an update pending
        step();
        upd(1'b1, 32'h100, 1'b0);
        step();
        upd(1'b0, 32'h0, 1'b0);
        fetch(32'h100, BEQ_NEG8);
        expect_pred("rearm", 1'b0, 32'h0F8, 1'b1);
        step();
        upd(1'b1, 32'h100, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        fetch(32'h100, BEQ_NEG8);
        expect_pred("rst_async", 1'b1, 32'h0F8, 1'b0);
        fetch_pc    = 32'h400;
        fetch_rdata = JAL_POS16;
        fetch_valid = 1'b0;
        #1;
        check("rst_gate.taken", {31'b0, pred_taken}, 32'd0);
        check("rst_gate.hit", {31'b0, pred_hit}, 32'd0);
        step();
        rst = 1'b0;
        upd(1'b0, 32'h0, 1'b0);
        fetch(32'h100, BEQ_POS8);
        expect_pred("rst_lost", 1'b0, 32'h108, 1'b0);

        // Updates resume on the first edge after reset release
        upd(1'b1, 32'h100, 1'b1);
        step();
        upd(1'b0, 32'h0, 1'b0);
        fetch(32'h100, BEQ_POS8);
        expect_pred("post_rst", 1'b1, 32'h108, 1'b1);
        fetch_valid = 1'b0;
        #1;
        check("gate.taken", {31'b0, pred_taken}, 32'd0);
        check("gate.hit", {31'b0, pred_hit}, 32'd0);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
